// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch (IF) and data (MA) requesters with a fixed-latency request/accept
// sequence on the memory side. Data wins on simultaneous requests.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive data
// grants made while IF was waiting, the next arbitration goes to IF.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic [3:0]        dm_mask_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_mask_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 3;
  localparam int unsigned MASK_W   = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Reject latencies the 3-bit latency counter cannot express.
  generate
    if (MEM_LAT == 0 || MEM_LAT > 7 || STARVE_MAX > 7) begin : g_param_check
      $error("mem_port_arbiter: MEM_LAT must be 1..7 and STARVE_MAX at most 7");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_done_q, dm_done_d;
  logic              force_inst;
  logic              grant_data;
  logic              grant_inst;

`ifdef ARB_STARVE_GUARD_EN
  logic [STARVE_W-1:0] starve_q, starve_d;

  // IF has waited through STARVE_MAX data grants: it takes the next slot.
  assign force_inst = if_req_i && (starve_q == STARVE_W'(STARVE_MAX));
`else
  assign force_inst = 1'b0;
`endif

  assign grant_data = dm_req_i && !force_inst;
  assign grant_inst = if_req_i && !grant_data;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_done_d   = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    starve_d    = starve_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          mem_mask_d  = dm_mask_i;
        end else if (grant_inst) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_INST;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          mem_mask_d  = '0;
        end
`ifdef ARB_STARVE_GUARD_EN
        if (grant_data && if_req_i) begin
          starve_d = starve_q + STARVE_W'(1);
        end else if (grant_inst) begin
          starve_d = '0;
        end
`endif
      end

      S_ISSUE: begin
        if (mem_ready_i) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          mem_mask_d  = '0;
          if (mem_we_q) begin
            state_d    = S_DONE;
            if_valid_d = (owner_q == OWN_INST);
            dm_done_d  = (owner_q == OWN_DATA);
          end else begin
            lat_cnt_d = LAT_W'(MEM_LAT - 1);
            state_d   = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = S_DONE;
          if (owner_q == OWN_DATA) begin
            dm_rdata_d = mem_rdata_i;
            dm_done_d  = 1'b1;
          end else begin
            if_rdata_d = mem_rdata_i;
            if_valid_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_INST;
      lat_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_done_q   <= dm_done_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  // Starvation counter register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_mask_o  = mem_mask_q;

  // Hold the pipeline while any raised request has not yet completed.
  assign stall_o = (dm_req_i && !dm_done_q) || (if_req_i && !if_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a transaction-level
// model (timestamps for accept/capture/complete, plus a word memory).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 3;
  localparam int unsigned SMAX = 4;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_valid_o;
  logic          dm_req_i = 1'b0;
  logic          dm_we_i = 1'b0;
  logic [AW-1:0] dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0;
  logic [3:0]    dm_mask_i = '0;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_done_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_mask_o;
  logic          mem_ready_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          stall_o;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_mask_i(dm_mask_i), .dm_rdata_o(dm_rdata_o), .dm_done_o(dm_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_mask_o(mem_mask_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  // Word memory behind the arbiter; unwritten words read a fixed hash.
  logic [31:0] mem_a [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Transaction-level reference: one access in flight, timestamps for its phases.
  bit          m_busy = 1'b0;
  bit          m_issue = 1'b0;
  bit          m_own_d = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_maddr = '0;
  logic [31:0] m_wd = '0;
  logic [3:0]  m_mask = '0;
  int          m_done_at = -1;
  int          m_rd_at = -1;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_dm_rd = '0;
`ifdef ARB_STARVE_GUARD_EN
  int          m_starve = 0;
`endif
  bit          e_ifv, e_dmd, e_stall, g_data;

  always @(negedge clk_i) begin
    e_ifv   = m_busy && (m_done_at == cyc) && !m_own_d;
    e_dmd   = m_busy && (m_done_at == cyc) && m_own_d;
    e_stall = (dm_req_i && !e_dmd) || (if_req_i && !e_ifv);
    if (cmp_en) begin
      chk1("mem_req_o", mem_req_o, m_issue);
      chk1("mem_we_o", mem_we_o, m_issue && m_we);
      chk("mem_addr_o", mem_addr_o, m_maddr);
      chk("mem_wdata_o", mem_wdata_o, m_issue ? m_wd : 32'h0);
      chk("mem_mask_o", 32'(mem_mask_o), m_issue ? 32'(m_mask) : 32'h0);
      chk1("if_valid_o", if_valid_o, e_ifv);
      chk1("dm_done_o", dm_done_o, e_dmd);
      chk("if_rdata_o", if_rdata_o, m_if_rd);
      chk("dm_rdata_o", dm_rdata_o, m_dm_rd);
      chk1("stall_o", stall_o, e_stall);
    end
    if (!reset_n_i) begin
      m_busy = 0; m_issue = 0; m_done_at = -1; m_rd_at = -1;
      m_if_rd = '0; m_dm_rd = '0; m_maddr = '0;
`ifdef ARB_STARVE_GUARD_EN
      m_starve = 0;
`endif
    end else if (!m_busy) begin
      g_data = dm_req_i;
`ifdef ARB_STARVE_GUARD_EN
      if (if_req_i && m_starve == int'(SMAX)) g_data = 1'b0;
`endif
      if (g_data) begin
        m_busy = 1; m_issue = 1; m_own_d = 1; m_we = dm_we_i;
        m_addr = dm_addr_i; m_maddr = dm_addr_i; m_wd = dm_wdata_i; m_mask = dm_mask_i;
`ifdef ARB_STARVE_GUARD_EN
        if (if_req_i) m_starve++;
`endif
      end else if (if_req_i) begin
        m_busy = 1; m_issue = 1; m_own_d = 0; m_we = 0;
        m_addr = if_addr_i; m_maddr = if_addr_i; m_wd = '0; m_mask = '0;
`ifdef ARB_STARVE_GUARD_EN
        m_starve = 0;
`endif
      end
    end else begin
      if (m_rd_at == cyc) begin
        if (m_own_d) m_dm_rd = mem_rdata_i;
        else m_if_rd = mem_rdata_i;
        m_rd_at = -1;
      end
      if (m_issue && mem_ready_i) begin
        m_issue = 0;
        if (m_we) begin
          mem_a[m_addr] = m_wd;
          m_done_at = cyc + 1;
        end else begin
          m_rd_at   = cyc + int'(LAT);
          m_done_at = cyc + int'(LAT) + 1;
        end
      end else if (m_done_at == cyc) begin
        m_busy = 0;
        m_done_at = -1;
      end
    end
  end

  // Advance one cycle; the memory returns read data only in its latency slot.
  task automatic tick();
    @(posedge clk_i);
    #1;
    mem_rdata_i = (m_rd_at == cyc) ? mem_rd(m_addr) : $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if_req_i = 0; dm_req_i = 0; mem_ready_i = 1;
    end
  endtask

  logic [31:0] sweep_addr [3];
  int  k, last_t, nd, nd_at_if;
  bit  want, got;

  initial begin
    sweep_addr[0] = 32'h0; sweep_addr[1] = 32'h4; sweep_addr[2] = 32'h8;
    mem_a[32'h100] = 32'hDEAD_BEEF;

    tick();
    tick();
    #1;
    cmp_en = 1'b1;
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    chk1("rst_if_valid", if_valid_o, 1'b0);
    chk1("rst_dm_done", dm_done_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    reset_n_i = 1'b1;
    idle(2);

    // IF read of 0x100 with the memory always ready.
    for (int r = 0; r <= int'(LAT) + 3; r++) begin
      tick();
      mem_ready_i = 1; if_req_i = (r <= int'(LAT) + 2); if_addr_i = 32'h100;
      #1;
      if (r == 0) chk1("a_stall_req", stall_o, 1'b1);
      if (r == 1) begin
        chk1("a_mem_req", mem_req_o, 1'b1);
        chk("a_mem_addr", mem_addr_o, 32'h100);
      end
      if (r == int'(LAT) + 1) chk1("a_not_early", if_valid_o, 1'b0);
      if (r == int'(LAT) + 2) begin
        chk1("a_valid", if_valid_o, 1'b1);
        chk("a_rdata", if_rdata_o, 32'hDEAD_BEEF);
        chk1("a_stall_done", stall_o, 1'b0);
      end
      if (r == int'(LAT) + 3) chk("a_rdata_hold", if_rdata_o, 32'hDEAD_BEEF);
    end
    idle(2);

    // Data write to 0x2000 with ready held low for two cycles.
    for (int r = 0; r <= 5; r++) begin
      tick();
      dm_req_i = (r < 4); dm_we_i = 1; dm_addr_i = 32'h2000;
      dm_wdata_i = 32'h1234_5678; dm_mask_i = 4'hF; mem_ready_i = (r >= 3);
      #1;
      if (r >= 1 && r <= 3) begin
        chk1("b_mem_req", mem_req_o, 1'b1);
        chk1("b_mem_we", mem_we_o, 1'b1);
        chk1("b_no_done", dm_done_o, 1'b0);
      end
      if (r == 3) begin
        chk("b_wdata", mem_wdata_o, 32'h1234_5678);
        chk("b_mask", 32'(mem_mask_o), 32'hF);
      end
      if (r == 4) begin
        chk1("b_done", dm_done_o, 1'b1);
        chk1("b_req_drop", mem_req_o, 1'b0);
      end
      if (r == 5) begin
        chk1("b_done_once", dm_done_o, 1'b0);
        chk("b_addr_hold", mem_addr_o, 32'h2000);
        chk1("b_we_clear", mem_we_o, 1'b0);
      end
    end
    idle(2);

    // Simultaneous IF 0x4 and data read 0x80: data first.
    for (int r = 0; r <= 2 * int'(LAT) + 6; r++) begin
      tick();
      mem_ready_i = 1; dm_we_i = 0; dm_addr_i = 32'h80;
      dm_req_i = (r <= int'(LAT) + 2);
      if_req_i = (r <= 2 * int'(LAT) + 5); if_addr_i = 32'h4;
      #1;
      if (r == 1) chk("c_data_first", mem_addr_o, 32'h80);
      if (r == int'(LAT) + 2) begin
        chk1("c_dm_done", dm_done_o, 1'b1);
        chk("c_dm_rdata", dm_rdata_o, mem_rd(32'h80));
        chk1("c_stall_if_waits", stall_o, 1'b1);
      end
      if (r == int'(LAT) + 3) chk1("c_idle_no_req", mem_req_o, 1'b0);
      if (r == int'(LAT) + 4) begin
        chk1("c_if_mem_req", mem_req_o, 1'b1);
        chk("c_if_addr", mem_addr_o, 32'h4);
      end
      if (r == 2 * int'(LAT) + 4) chk1("c_if_not_early", if_valid_o, 1'b0);
      if (r == 2 * int'(LAT) + 5) begin
        chk1("c_if_valid", if_valid_o, 1'b1);
        chk("c_if_rdata", if_rdata_o, mem_rd(32'h4));
      end
    end
    idle(2);

    // Reset while the IF read of 0x300 is waiting for data.
    for (int r = 0; r <= 10; r++) begin
      tick();
      mem_ready_i = 1; if_req_i = (r <= 9); if_addr_i = 32'h300;
      reset_n_i = (r != 3);
      #1;
      if (r == 4) begin
        chk1("d_rst_req", mem_req_o, 1'b0);
        chk("d_rst_addr", mem_addr_o, 32'h0);
        chk("d_rst_if_rdata", if_rdata_o, 32'h0);
        chk("d_rst_dm_rdata", dm_rdata_o, 32'h0);
        chk1("d_rst_valid", if_valid_o, 1'b0);
      end
      if (r == 5) begin
        chk1("d_no_stale_pulse", if_valid_o, 1'b0);
        chk1("d_reissue", mem_req_o, 1'b1);
        chk("d_reissue_addr", mem_addr_o, 32'h300);
      end
      if (r == 4 + int'(LAT) + 1) chk1("d_not_early", if_valid_o, 1'b0);
      if (r == 4 + int'(LAT) + 2) begin
        chk1("d_valid", if_valid_o, 1'b1);
        chk("d_rdata", if_rdata_o, mem_rd(32'h300));
      end
    end
    idle(2);

    // Back-to-back IF reads: completions LAT+3 cycles apart.
    k = 0; last_t = -1; want = 1;
    for (int r = 0; r < 80 && k < 3; r++) begin
      tick();
      mem_ready_i = 1;
      if (if_valid_o) begin
        chk("e_rdata", if_rdata_o, mem_rd(sweep_addr[k]));
        if (last_t >= 0) chk("e_spacing", 32'(cyc - last_t), 32'(LAT + 3));
        last_t = cyc; k++; if_req_i = 0; want = 1;
      end else if (want) begin
        if_req_i = 1; if_addr_i = sweep_addr[k]; want = 0;
      end
    end
    chk("e_count", 32'(k), 32'd3);
    idle(2);

    // Continuous data traffic while IF waits.
    nd = 0; nd_at_if = -1; dm_addr_i = 32'h1000; dm_we_i = 0;
    for (int r = 0; r < 150 && nd < 6; r++) begin
      tick();
      mem_ready_i = 1;
      if (dm_done_o) begin
        nd++;
        dm_addr_i = 32'h1000 + 32'(nd) * 4;
      end
      if (if_valid_o && nd_at_if < 0) nd_at_if = nd;
      dm_req_i = (nd < 6);
      if_req_i = (nd_at_if < 0); if_addr_i = 32'h40;
    end
    chk("f_data_count", 32'(nd), 32'd6);
`ifdef ARB_STARVE_GUARD_EN
    chk("f_if_after_data", 32'(nd_at_if), 32'(SMAX));
`else
    chk("f_if_starved", 32'(nd_at_if), 32'hFFFF_FFFF);
    got = 0;
    for (int r = 0; r < 40 && !got; r++) begin
      tick();
      mem_ready_i = 1;
      if (if_valid_o) begin got = 1; if_req_i = 0; end
    end
    chk1("f_if_drain", got, 1'b1);
`endif
    idle(3);

    // Randomized traffic with random ready and occasional reset.
    for (int r = 0; r < 3000; r++) begin
      tick();
      reset_n_i   = ($urandom_range(0, 199) != 0);
      mem_ready_i = ($urandom_range(0, 2) != 0);
      if (!(if_req_i && !if_valid_o)) begin
        if_req_i  = ($urandom_range(0, 3) == 0);
        if_addr_i = 32'($urandom_range(0, 63)) << 2;
      end
      if (!(dm_req_i && !dm_done_o)) begin
        dm_req_i   = ($urandom_range(0, 2) == 0);
        dm_we_i    = ($urandom_range(0, 1) == 0);
        dm_addr_i  = 32'($urandom_range(0, 63)) << 2;
        dm_wdata_i = $urandom;
        dm_mask_i  = 4'($urandom);
      end
    end
    reset_n_i = 1;
    for (int r = 0; r < 40; r++) begin
      tick();
      mem_ready_i = 1;
      if (if_valid_o) if_req_i = 0;
      if (dm_done_o) dm_req_i = 0;
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
